load_store_unit: RTL

Load/store unit between the execute stage and the word-organised data memory. It accepts one memory request at a time from execute. It checks alignment, range and funct3 legality, and drives the memory's word-wide read/write port. Sub-word stores are done as read-modify-write, since the memory has no byte enables. Load data is extracted and sign- or zero-extended, and a tagged result goes back towards writeback.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: checks and executes one word-memory request at a time, sub-word stores as read-modify-write.
// Latency from acceptance: load 2, SW 2, SB/SH 3, error 1 cycle.
// Backpressure: holds the response in RESP until resp_ready; req_ready only in IDLE.
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    state_t      state_q, state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [4:0]  rd_q;
    logic [1:0]  err_q;
    logic [1:0]  err_in;
    logic        accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    // Classify the incoming request; illegal funct3 beats misalignment beats range.
    always_comb begin
        err_in = 2'b00;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_funct3[2] && req_write)) begin
            err_in = 2'b11;
        end else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)) begin
            err_in = 2'b01;
        end else if (req_addr >= ADDR_LIMIT) begin
            err_in = 2'b10;
        end
    end

    // State register, request latch and read-word capture; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rd_q     <= 5'h0;
            err_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
                err_q    <= err_in;
            end
            if (state_q == READ) begin
                word_q <= mem_rdata;
            end
        end
    end

    // Next-state selection: errors skip memory, SW writes directly, SB/SH read first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (err_in != 2'b00) begin
                        state_d = RESP;
                    end else if (req_write && req_funct3 == 3'b010) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Pick the addressed lane out of the captured word and extend it.
    always_comb begin
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = word_q[7:0];
            2'd1:    ld_byte = word_q[15:8];
            2'd2:    ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = word_q;
        endcase
    end

    // Build the store word: SW passes through, SB/SH splice into the captured word.
    always_comb begin
        merged = word_q;
        case (funct3_q)
            3'b000: begin
                case (addr_q[1:0])
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            3'b001: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Drive handshake and memory port; everything is forced quiet while reset is high.
    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        mem_read   = (state_q == READ) && !reset;
        mem_write  = (state_q == WRITE) && !reset;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        resp_valid = (state_q == RESP) && !reset;
        resp_rdata = 32'h0;
        resp_rd    = 5'h0;
        resp_err   = 2'b00;
        if (mem_read || mem_write) begin
            mem_addr = {2'b00, addr_q[31:2]};
        end
        if (mem_write) begin
            mem_wdata = merged;
        end
        if (resp_valid) begin
            resp_rd  = rd_q;
            resp_err = err_q;
            if (!write_q && err_q == 2'b00) begin
                resp_rdata = ld_data;
            end
        end
    end
endmodule
